// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared types and constants for the hazard scoreboard.
//   sb_entry_t   : one in-flight pipeline entry {valid, wen, wreg, tnew}
//   TUSE_UNUSED  : Tuse value meaning "operand not read" (all ones)
//   *_LAT_DEF    : default MDU busy latencies
// Entry fields are sized to the largest supported REG_W / T_W; narrower
// parameterisations zero-extend into them.
package hazard_scoreboard_pkg;

  localparam int unsigned SB_REG_W_MAX = 8;
  localparam int unsigned SB_T_W_MAX   = 4;

  localparam int unsigned REG_W_DEF    = 5;
  localparam int unsigned T_W_DEF      = 2;
  localparam int unsigned DEPTH_DEF    = 3;
  localparam int unsigned MULT_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF  = 10;

  localparam logic [T_W_DEF-1:0] TUSE_UNUSED = '1;

  typedef struct packed {
    logic                    valid;
    logic                    wen;
    logic [SB_REG_W_MAX-1:0] wreg;
    logic [SB_T_W_MAX-1:0]   tnew;
  } sb_entry_t;

  // Counter width able to hold the larger of the two latencies.
  function automatic int unsigned md_cnt_w(input int unsigned mult_lat,
                                           input int unsigned div_lat);
    int unsigned max_lat;
    max_lat = (mult_lat > div_lat) ? mult_lat : div_lat;
    return $clog2(max_lat + 1);
  endfunction

  // Advance an entry by one stage: tnew counts down and saturates at 0.
  function automatic sb_entry_t age_entry(input sb_entry_t e);
    sb_entry_t a;
    a = e;
    if (a.tnew != '0) a.tnew = a.tnew - SB_T_W_MAX'(1);
    return a;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: D-stage issue bus and hazard outputs.
//   master: drives D_* issue fields and flush; observes stall, md_busy
//   slave : the scoreboard; consumes D_* and flush; drives stall, md_busy
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF,
  parameter int unsigned T_W   = T_W_DEF
);

  logic [REG_W-1:0] D_rs;
  logic [REG_W-1:0] D_rt;
  logic [T_W-1:0]   D_TuseRs;
  logic [T_W-1:0]   D_TuseRt;
  logic             D_wen;
  logic [REG_W-1:0] D_wreg;
  logic [T_W-1:0]   D_Tnew;
  logic             D_mdStart;
  logic             D_mdIsDiv;
  logic             D_mdUse;
  logic             flush;
  logic             stall;
  logic             md_busy;

  modport master (
    output D_rs, D_rt, D_TuseRs, D_TuseRt, D_wen, D_wreg, D_Tnew,
           D_mdStart, D_mdIsDiv, D_mdUse, flush,
    input  stall, md_busy
  );

  modport slave (
    input  D_rs, D_rt, D_TuseRs, D_TuseRt, D_wen, D_wreg, D_Tnew,
           D_mdStart, D_mdIsDiv, D_mdUse, flush,
    output stall, md_busy
  );

endinterface

// File: rtl/hazard_scoreboard_md_busy_cnt.sv
// md_busy_cnt: multiply/divide unit busy counter.
//   clk, reset : clock, async active-high reset
//   i_start    : accepted MDU start (already qualified by !stall)
//   i_is_div   : load DIV_LAT instead of MULT_LAT
//   i_flush    : discard any remaining count at the next edge
//   o_busy     : counter non-zero
module md_busy_cnt
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_is_div,
  input  logic i_flush,
  output logic o_busy
);

  localparam int unsigned CNT_W = md_cnt_w(MULT_LAT, DIV_LAT);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_busy;

  // Flush beats start; a start in the last busy cycle reloads without a gap.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_flush) begin
      w_cnt_nxt = '0;
    end else if (i_start) begin
      w_cnt_nxt = i_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end

  // Busy flag registered alongside the count so it tracks it exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_busy <= (w_cnt_nxt != '0);
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: Tuse/Tnew stall generator for an in-order pipeline.
//   clk, reset : clock, async active-high reset
//   bus.D_*    : D-stage source regs, Tuse, destination, Tnew, MDU controls
//   bus.flush  : kill all tracked entries and the MDU count at the next edge
//   bus.stall  : combinational; freeze PC/D and inject a bubble into E
//   bus.md_busy: MDU busy counter non-zero
// Entry 0 is E, entry DEPTH-1 is the oldest tracked stage.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_W    = REG_W_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned T_W      = T_W_DEF,
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  hazard_scoreboard_if.slave  bus
);

  sb_entry_t        r_sb [DEPTH];
  sb_entry_t        w_d_entry;
  logic [DEPTH-1:0] w_haz_rs;
  logic [DEPTH-1:0] w_haz_rt;
  logic             w_md_busy;
  logic             w_md_hazard;
  logic             w_md_start;
  logic             w_stall;

  // Entry presented to E: the D instruction, or a bubble while stalling.
  always_comb begin
    w_d_entry = '0;
    if (!w_stall) begin
      w_d_entry.valid = 1'b1;
      w_d_entry.wen   = bus.D_wen;
      w_d_entry.wreg  = SB_REG_W_MAX'(bus.D_wreg);
      w_d_entry.tnew  = SB_T_W_MAX'(bus.D_Tnew);
    end
  end

  // Pipeline shift; flush clears every entry and suppresses the new load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(DEPTH); k++) r_sb[k] <= '0;
    end else if (bus.flush) begin
      for (int k = 0; k < int'(DEPTH); k++) r_sb[k] <= '0;
    end else begin
      r_sb[0] <= w_d_entry;
      for (int k = 1; k < int'(DEPTH); k++) r_sb[k] <= age_entry(r_sb[k-1]);
    end
  end

  // Per-entry hazard compare; rs and rt are checked independently.
  for (genvar k = 0; k < int'(DEPTH); k++) begin : g_haz
    assign w_haz_rs[k] = r_sb[k].valid & r_sb[k].wen &
                         (r_sb[k].wreg == SB_REG_W_MAX'(bus.D_rs)) &
                         (bus.D_rs != '0) &
                         (SB_T_W_MAX'(bus.D_TuseRs) < r_sb[k].tnew);
    assign w_haz_rt[k] = r_sb[k].valid & r_sb[k].wen &
                         (r_sb[k].wreg == SB_REG_W_MAX'(bus.D_rt)) &
                         (bus.D_rt != '0) &
                         (SB_T_W_MAX'(bus.D_TuseRt) < r_sb[k].tnew);
  end

  assign w_md_hazard = bus.D_mdUse & w_md_busy;
  assign w_stall     = (|w_haz_rs) | (|w_haz_rt) | w_md_hazard;
  assign w_md_start  = bus.D_mdStart & ~w_stall;

  md_busy_cnt #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_busy_cnt (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_md_start),
    .i_is_div (bus.D_mdIsDiv),
    .i_flush  (bus.flush),
    .o_busy   (w_md_busy)
  );

  assign bus.stall   = w_stall;
  assign bus.md_busy = w_md_busy;

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have parameter REG_W, default 5, meaning the register-number width.
REQ-002 The block SHALL have parameter DEPTH, default 3, meaning the number of tracked in-flight stages after D (entry 0 = E, 1 = M, 2 = W).
REQ-003 The block SHALL have parameter T_W, default 2, meaning the width of all Tuse/Tnew fields.
REQ-004 The block SHALL have parameter MULT_LAT, default 5, meaning the mult busy cycles.
REQ-005 The block SHALL have parameter DIV_LAT, default 10, meaning the div busy cycles.
REQ-006 The block SHALL have these ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- D_rs, D_rt  in  REG_W  source registers of the D-stage instruction.
- D_TuseRs, D_TuseRt  in  T_W  cycles until D needs rs/rt; max value = unused.
- D_wen  in  1  D instruction writes a GPR.
- D_wreg  in  REG_W  destination register.
- D_Tnew  in  T_W  Tnew the instruction will have on entering E.
- D_mdStart  in  1  D is mult/div.
- D_mdIsDiv  in  1  selects DIV_LAT over MULT_LAT.
- D_mdUse  in  1  D reads or writes HI/LO or starts the MDU.
- flush  in  1  kill all tracked entries.
- stall  out  1  freeze PC and D register; inject a bubble into E.
- md_busy  out  1  MDU counter non-zero.

Function
REQ-007 Scoreboard SHALL hold DEPTH entries {valid, wen, wreg, tnew}.
REQ-008 Every cycle, entry k SHALL move to entry k+1, with tnew decremented and saturated at 0; the last entry SHALL be discarded.
REQ-009 When stall=0, entry 0 SHALL load {1, D_wen, D_wreg, D_Tnew}; when stall=1, entry 0 SHALL load a bubble (valid=0).
REQ-010 Entry k SHALL be a rs-hazard when valid & wen & wreg==D_rs & D_rs!=0 & D_TuseRs<tnew; the rt-hazard SHALL be the same test on D_rt/D_TuseRt.
REQ-011 The MDU counter SHALL have width clog2(max(MULT_LAT,DIV_LAT)+1).
REQ-012 When D_mdStart & !stall, the MDU counter SHALL load DIV_LAT if D_mdIsDiv, else MULT_LAT; otherwise it SHALL decrement while non-zero.
REQ-013 md_busy SHALL be 1 whenever the counter is non-zero.
REQ-014 md_hazard SHALL be D_mdUse & md_busy.
REQ-015 stall SHALL be the combinational OR of all rs/rt hazards and md_hazard, with no register between the hazard and stall.
REQ-016 flush SHALL clear all valid bits and the MDU counter at the next edge and override the loads of REQ-009 and REQ-012.
REQ-017 stall from a cleared state SHALL be 0 in the cycle flush is sampled only if the combinational terms are 0; flush SHALL take effect from the following cycle.
REQ-018 A start issued in the cycle the counter reaches 1 SHALL reload the counter, with no idle gap.
REQ-019 D_rs==D_rt SHALL be evaluated per field independently.

Reset
REQ-020 Asserting reset SHALL clear all valid bits, wen, wreg and tnew to 0 and the MDU counter to 0, immediately and without clk.
REQ-021 During and after reset, stall and md_busy SHALL be 0 until new issues occur.
REQ-022 Reset mid-MDU-operation SHALL discard the remaining count.

Structure
REQ-023 A shared package SHALL hold the entry struct typedef, the Tuse "unused" constant, and the MULT/DIV default latencies.
REQ-024 The MDU busy counter SHALL be one sub-module, md_busy_cnt; the scoreboard SHALL remain inline with a generate loop over DEPTH.

Verification
REQ-025 The bench SHALL cover load-use:
- Stimulus: lw $8 issued (D_Tnew=2), then D_rs=8 with TuseRs=0.
- Response: stall=1 for 2 cycles, then 0.
REQ-026 The bench SHALL cover ALU forwarding: add $8 (Tnew=1) then TuseRs=1 reader -> stall=0 throughout.
REQ-027 The bench SHALL cover $0 writes: a write to $0 with Tnew=2 and a reader of $0 -> stall=0.
REQ-028 The bench SHALL cover MDU busy:
- Stimulus: div issued, then mfhi (D_mdUse=1) next cycle.
- Response: md_busy=1 and stall=1 for exactly 10 cycles.
- Parameter variant: MULT_LAT=3 gives 3 cycles.
REQ-029 The bench SHALL cover flush:
- Stimulus: lw $9 in E, reader of $9 in D, flush pulse.
- Response: stall=0 from the next cycle; md_busy cleared.
REQ-030 The bench SHALL cover async reset:
- Stimulus: reset asserted mid-div between clock edges.
- Response: md_busy=0 and stall=0 before the next clk edge.
